banco_registros_param: RTL
==========================

Name: banco_registros_param

Overview:
Parametrised successor of the core register file: configurable data width, register count and number of read ports.
Adds a per-register scoreboard (pending-write bits) for the pipelined micro's hazard unit.
Adds a multi-cycle sweep-clear sequencer that zeroes the file without a global reset.
Sits in decode: read ports feed the operand muxes, the write port is driven by writeback, and issue/scoreboard is driven by the issue stage.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; NREG = 2**ADDR_W
NREAD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1: register 0 hardwired to zero and never marked pending; 0: register 0 is ordinary

Ports:
CLK  input  1  clock, rising edge
RST_n  input  1  reset, asynchronous, active-low
readReg  input  NREAD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
readData  output  NREAD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W]
readBusy  output  NREAD  port i: pending bit of readReg[i]
RegWrite  input  1  write enable
writeReg  input  ADDR_W  write address
writeData  input  DATA_W  write data
issueValid  input  1  mark issueReg pending (instruction issued with destination issueReg)
issueReg  input  ADDR_W  destination being issued
clearReq  input  1  start a sweep-clear (level sampled in IDLE)
clearBusy  output  1  high while the sweep is running
clearDone  output  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset (async, RST_n=0): all registers 0, all pending bits 0, FSM=IDLE, sweep index 0.
  Outputs: readData = 0 on every port, readBusy = 0, clearBusy = 0, clearDone = 0.
- Reads: combinational. readData[i] = reg[readReg[i]]; readBusy[i] = pending[readReg[i]].
- Write: on posedge CLK, if RegWrite, FSM≠SWEEP, and not (ZERO_REG and writeReg==0), then reg[writeReg] <= writeData and pending[writeReg] <= 0. Visible on reads the next cycle.
- Issue: on posedge CLK, if issueValid, FSM≠SWEEP, and not (ZERO_REG and issueReg==0), then pending[issueReg] <= 1.
- Issue and write to the same register in the same cycle: the data is written and pending ends at 1 (the new producer wins).
- ZERO_REG=1: reg[0] always reads 0 and readBusy is never set for address 0.
- FSM states:
  - IDLE: clearReq=1 -> SWEEP with idx=0.
  - SWEEP: each cycle reg[idx] <= 0, pending[idx] <= 0, idx++. At idx==NREG-1 -> DONE. Takes NREG cycles, idx wraps to 0. RegWrite and issueValid are ignored. Reads return current contents (partially cleared). clearReq is ignored.
  - DONE: clearDone=1 for one cycle -> IDLE. Writes and issues are accepted again in this cycle.
- clearBusy=1 exactly while FSM=SWEEP.
- Latency from clearReq sampled in IDLE to clearDone: NREG+1 cycles.
- RST_n asserted mid-sweep: immediate return to IDLE with everything zeroed; no clearDone pulse.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. For each port i, if RegWrite, FSM≠SWEEP, writeReg==readReg[i], and not (ZERO_REG and address 0), then readData[i] = writeData and readBusy[i] = 0 in the same cycle.
- Not defined: no forwarding. A read of the register being written returns the old value and the old pending bit until the next cycle.

Decomposition:
- Package regfile_pkg holds:
  - typedef enum logic [1:0] {IDLE, SWEEP, DONE} clr_state_t
  - default width constants REGFILE_DATA_W=32, REGFILE_ADDR_W=5
- One natural sub-module, regfile_clear_fsm: owns state, idx, clearBusy and clearDone; outputs sweepEn and sweepIdx to the storage array.

Test Plan:
- Reset then write 0xDEADBEEF to reg 5; next cycle readReg0=5 -> readData0=0xDEADBEEF, readBusy0=0. Write reg 0 with 0x1234 (ZERO_REG=1) -> reads 0.
- issueValid on reg 7 -> readBusy=1 the following cycle. RegWrite reg 7 with 0x55 -> readBusy=0 and readData=0x55. Same-cycle issue and write on reg 7 -> data 0x55, readBusy stays 1.
- NREAD=3: ports read regs 1, 2, 1 with values 0x11 and 0x22 -> readData={0x11,0x22,0x11}.
- Fill all 32 registers with nonzero values, pulse clearReq -> clearBusy high for 32 cycles, clearDone at cycle 33, all reads 0 afterwards. RegWrite of 0x99 during the sweep is discarded.
- Assert RST_n=0 at sweep cycle 10 -> clearBusy drops immediately, no clearDone, all registers 0.
- REGFILE_BYPASS_EN defined: RegWrite reg 3 with 0xA5 while readReg0=3 -> readData0=0xA5 in the same cycle. Not defined -> old value that cycle, 0xA5 the next.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default widths for the parametrised register file.
// Build option: REGFILE_BYPASS_EN enables write-to-read forwarding in banco_registros_param.
package regfile_pkg;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} clr_state_t;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_ADDR_W = 5;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sweep-clear sequencer: walks every register index once, then pulses done.
// Latency clearReq->done is NREG+1 cycles; clear_req is ignored outside IDLE.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              clear_req,
    output logic              sweep_en,
    output logic [ADDR_W-1:0] sweep_idx,
    output logic              clear_busy,
    output logic              clear_done
);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                // index wraps back to 0 on the last register
                idx_d = idx_q + 1'b1;
                if (idx_q == {ADDR_W{1'b1}}) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sweep_en   = (state_q == SWEEP);
    assign sweep_idx  = idx_q;
    assign clear_busy = (state_q == SWEEP);
    assign clear_done = (state_q == DONE);

endmodule

// File: rtl/banco_registros_param.sv
// Multi-port register file with pending-write scoreboard and sweep-clear; reads are combinational.
// Writes/issues are dropped while sweeping; REGFILE_BYPASS_EN forwards same-cycle writes to reads.
module banco_registros_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REGFILE_DATA_W,
    parameter int ADDR_W   = REGFILE_ADDR_W,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic [NREAD*ADDR_W-1:0] readReg,
    output logic [NREAD*DATA_W-1:0] readData,
    output logic [NREAD-1:0]        readBusy,
    input  logic                    RegWrite,
    input  logic [ADDR_W-1:0]       writeReg,
    input  logic [DATA_W-1:0]       writeData,
    input  logic                    issueValid,
    input  logic [ADDR_W-1:0]       issueReg,
    input  logic                    clearReq,
    output logic                    clearBusy,
    output logic                    clearDone
);

    localparam int NREG    = 2 ** ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] reg_q [NREG];
    logic [DATA_W-1:0] reg_d [NREG];
    logic [NREG-1:0]   pend_q, pend_d;

    logic              sweep_en;
    logic [ADDR_W-1:0] sweep_idx;
    logic              wr_en, iss_en;

    regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .clear_req  (clearReq),
        .sweep_en   (sweep_en),
        .sweep_idx  (sweep_idx),
        .clear_busy (clearBusy),
        .clear_done (clearDone)
    );

    // Register 0 is never written nor marked pending when hardwired, so it stays 0.
    assign wr_en  = RegWrite   && !sweep_en && !(ZERO_EN && (writeReg == '0));
    assign iss_en = issueValid && !sweep_en && !(ZERO_EN && (issueReg == '0));

    always_comb begin
        reg_d  = reg_q;
        pend_d = pend_q;
        if (sweep_en) begin
            reg_d[sweep_idx]  = '0;
            pend_d[sweep_idx] = 1'b0;
        end
        if (wr_en) begin
            reg_d[writeReg]  = writeData;
            pend_d[writeReg] = 1'b0;
        end
        // issue after write: a new producer keeps the register pending
        if (iss_en) pend_d[issueReg] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int r = 0; r < NREG; r++) reg_q[r] <= '0;
            pend_q <= '0;
        end else begin
            reg_q  <= reg_d;
            pend_q <= pend_d;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        assign rd_addr = readReg[p*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        logic fwd;
        assign fwd                         = wr_en && (writeReg == rd_addr);
        assign readData[p*DATA_W +: DATA_W] = fwd ? writeData : reg_q[rd_addr];
        assign readBusy[p]                  = fwd ? 1'b0 : pend_q[rd_addr];
`else
        assign readData[p*DATA_W +: DATA_W] = reg_q[rd_addr];
        assign readBusy[p]                  = pend_q[rd_addr];
`endif
    end

endmodule
